pipeline_hazard_ctrl: RTL and testbench

- Control unit that sequences the PC register, the IF/ID pipeline register and the ID/EX register of the 5-stage pipelined processor.
- Decides each cycle whether the PC advances, IF/ID latches or is flushed, and ID/EX receives a bubble.
- Handles three events: load-use hazards, taken branches resolved in EX, and instruction-memory wait states.
- Outputs are consumed by the PC mux, by the IF/ID register's write-enable and flush inputs, and by the ID/EX register's bubble input.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// register-specifier width and the NOP word that IF/ID loads on a flush.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t StRun       = 2'd0;
  localparam ctrl_state_t StLoadStall = 2'd1;
  localparam ctrl_state_t StFlush     = 2'd2;
  localparam ctrl_state_t StImemWait  = 2'd3;

  // MIPS sll $0,$0,0
  localparam logic [31:0] NopInstr = 32'h0000_0000;

  // Counter preload for a multi-cycle stall/flush: the first cycle is spent in
  // the state that detected the event, the last one with the counter at zero.
  function automatic logic [1:0] cnt_init(input int unsigned cycles);
    return (cycles > 1) ? 2'(cycles - 2) : 2'd0;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, register/PC controls out.
// With HAZ_PERF_CNT_EN defined, carries the stall/flush performance counters.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
);

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_branch_taken;
  logic                  imem_ready;
  logic                  pc_write_en;
  logic                  pc_sel;
  logic                  if_id_write_en;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic [1:0]            ctrl_state;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_cycles;
`endif

  // Pipeline side: drives status, observes controls
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, imem_ready,
    input  pc_write_en, pc_sel, if_id_write_en, if_id_flush, id_ex_bubble, ctrl_state
`ifdef HAZ_PERF_CNT_EN
    , input stall_cycles, flush_cycles
`endif
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, ex_branch_taken, imem_ready,
    output pc_write_en, pc_sel, if_id_write_en, if_id_flush, id_ex_bubble, ctrl_state
`ifdef HAZ_PERF_CNT_EN
    , output stall_cycles, flush_cycles
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Register 0 is hard-wired and never creates a hazard.
module pipeline_hazard_ctrl_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic                  load_use
);

  // Match on rs always, on rt only when the ID instruction reads it
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: drives PC write/select, IF/ID
// write/flush and the ID/EX bubble from load-use, taken-branch and imem-wait
// events. Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W          = RegAddrW,
  parameter int unsigned LOAD_STALL_CYCLES   = 1,
  parameter int unsigned BRANCH_FLUSH_CYCLES = 1
`ifdef HAZ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] LoadInit  = cnt_init(LOAD_STALL_CYCLES);
  localparam logic [1:0] FlushInit = cnt_init(BRANCH_FLUSH_CYCLES);

  ctrl_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        load_use;

  logic pc_write_en, pc_sel, if_id_write_en, if_id_flush, id_ex_bubble;

  pipeline_hazard_ctrl_load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .load_use    (load_use)
  );

  // Next state and combinational controls; branch outranks every state
  always_comb begin
    pc_write_en    = 1'b1;
    pc_sel         = 1'b0;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;

    if (bus.ex_branch_taken) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        cnt_d   = FlushInit;
      end else begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        StRun: begin
          // Load-use beats imem wait; the wait is seen again next cycle
          if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = StLoadStall;
              cnt_d   = LoadInit;
            end
          end else if (!bus.imem_ready) begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
            state_d     = StImemWait;
          end
        end
        StLoadStall: begin
          // EX holds a bubble now, so the hazard must be remembered here
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          if (cnt_q == '0) state_d = StRun;
          else             cnt_d   = cnt_q - 2'd1;
        end
        StFlush: begin
          pc_write_en  = bus.imem_ready;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q == '0) state_d = bus.imem_ready ? StRun : StImemWait;
          else             cnt_d   = cnt_q - 2'd1;
        end
        StImemWait: begin
          if (!bus.imem_ready) begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end

    // Reset holds the pipeline frozen with NOPs regardless of the clock
    if (rst) begin
      pc_write_en    = 1'b0;
      pc_sel         = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
    end
  end

  // State and stall counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write_en    = pc_write_en;
  assign bus.pc_sel         = pc_sel;
  assign bus.if_id_write_en = if_id_write_en;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_ex_bubble   = id_ex_bubble;
  assign bus.ctrl_state     = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_cycles_q;

  // Saturating stall/flush cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      if (!pc_write_en && !if_id_flush && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 1'b1;
      end
      if (if_id_flush && (flush_cycles_q != '1)) begin
        flush_cycles_q <= flush_cycles_q + 1'b1;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share one stimulus:
// dut_a (LOAD_STALL_CYCLES=2, BRANCH_FLUSH_CYCLES=1) and
// dut_b (LOAD_STALL_CYCLES=1, BRANCH_FLUSH_CYCLES=3).
// Output vectors are {pc_write_en, pc_sel, if_id_write_en, if_id_flush,
// id_ex_bubble, ctrl_state[1:0]}.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) bus_a ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) bus_b ();

  assign bus_b.id_rs           = bus_a.id_rs;
  assign bus_b.id_rt           = bus_a.id_rt;
  assign bus_b.id_uses_rt      = bus_a.id_uses_rt;
  assign bus_b.ex_mem_read     = bus_a.ex_mem_read;
  assign bus_b.ex_rt           = bus_a.ex_rt;
  assign bus_b.ex_branch_taken = bus_a.ex_branch_taken;
  assign bus_b.imem_ready      = bus_a.imem_ready;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W          (5),
    .LOAD_STALL_CYCLES   (2),
    .BRANCH_FLUSH_CYCLES (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipeline_hazard_ctrl #(
    .REG_ADDR_W          (5),
    .LOAD_STALL_CYCLES   (1),
    .BRANCH_FLUSH_CYCLES (3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [6:0] outs_a, outs_b;
  assign outs_a = {bus_a.pc_write_en, bus_a.pc_sel, bus_a.if_id_write_en, bus_a.if_id_flush,
                   bus_a.id_ex_bubble, bus_a.ctrl_state};
  assign outs_b = {bus_b.pc_write_en, bus_b.pc_sel, bus_b.if_id_write_en, bus_b.if_id_flush,
                   bus_b.id_ex_bubble, bus_b.ctrl_state};

  localparam logic [6:0] VRst     = 7'b0001100;
  localparam logic [6:0] VDef     = 7'b1010000;
  localparam logic [6:0] VLuRun   = 7'b0000100;
  localparam logic [6:0] VLuStall = 7'b0000101;
  localparam logic [6:0] VBrStall = 7'b1111101;
  localparam logic [6:0] VBrRun   = 7'b1111100;
  localparam logic [6:0] VIwRun   = 7'b0011000;
  localparam logic [6:0] VIwWait  = 7'b0011011;
  localparam logic [6:0] VIwDone  = 7'b1010011;
  localparam logic [6:0] VFlRdy   = 7'b1011110;
  localparam logic [6:0] VFlNrdy  = 7'b0011110;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", tag, got[6:0], exp[6:0]);
    end
  endtask

  // Apply one cycle of inputs on the falling edge and let outputs settle
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic br,
                       input logic rdy);
    @(negedge clk);
    bus_a.id_rs           = rs;
    bus_a.id_rt           = rt;
    bus_a.id_uses_rt      = uses;
    bus_a.ex_mem_read     = mr;
    bus_a.ex_rt           = ert;
    bus_a.ex_branch_taken = br;
    bus_a.imem_ready      = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst                   = 1'b1;
    bus_a.id_rs           = 5'd1;
    bus_a.id_rt           = 5'd2;
    bus_a.id_uses_rt      = 1'b0;
    bus_a.ex_mem_read     = 1'b0;
    bus_a.ex_rt           = 5'd0;
    bus_a.ex_branch_taken = 1'b0;
    bus_a.imem_ready      = 1'b1;
    #2;
    check_eq("reset_a", 32'(outs_a), 32'(VRst));
    check_eq("reset_b", 32'(outs_b), 32'(VRst));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_reset_a", 32'(outs_a), 32'(VDef));
    check_eq("post_reset_b", 32'(outs_b), 32'(VDef));

    // Load-use on rs: two freeze cycles on dut_a, one on dut_b
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    check_eq("lu_c1_a", 32'(outs_a), 32'(VLuRun));
    check_eq("lu_c1_b", 32'(outs_b), 32'(VLuRun));
    idle();
    check_eq("lu_c2_a", 32'(outs_a), 32'(VLuStall));
    check_eq("lu_c2_b", 32'(outs_b), 32'(VDef));
    idle();
    check_eq("lu_c3_a", 32'(outs_a), 32'(VDef));

    // Zero register and unused rt never stall
    drive(5'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1);
    check_eq("zero_reg_a", 32'(outs_a), 32'(VDef));
    drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1);
    check_eq("rt_unused_a", 32'(outs_a), 32'(VDef));
    check_eq("rt_unused_b", 32'(outs_b), 32'(VDef));

    // rt hazard, then a taken branch in the LOAD_STALL cycle
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);
    check_eq("rt_used_a", 32'(outs_a), 32'(VLuRun));
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    check_eq("br_in_stall_a", 32'(outs_a), 32'(VBrStall));
    idle();
    check_eq("br_after_a", 32'(outs_a), 32'(VDef));
    idle();
    idle();
    check_eq("br_recover_b", 32'(outs_b), 32'(VDef));

    // Instruction memory not ready for three cycles
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_eq("iw_c1_a", 32'(outs_a), 32'(VIwRun));
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_eq("iw_c2_a", 32'(outs_a), 32'(VIwWait));
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_eq("iw_c3_a", 32'(outs_a), 32'(VIwWait));
    idle();
    check_eq("iw_done_a", 32'(outs_a), 32'(VIwDone));
    idle();
    check_eq("iw_run_a", 32'(outs_a), 32'(VDef));

    // Asynchronous reset while dut_a sits in LOAD_STALL
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
    idle();
    check_eq("rst_pre_a", 32'(outs_a), 32'(VLuStall));
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_mid_a", 32'(outs_a), 32'(VRst));
    check_eq("rst_mid_b", 32'(outs_b), 32'(VRst));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_rel_a", 32'(outs_a), 32'(VDef));
    check_eq("rst_rel_b", 32'(outs_b), 32'(VDef));

    // Three-cycle flush on dut_b ending with imem not ready
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    check_eq("df_c1_b", 32'(outs_b), 32'(VBrRun));
    idle();
    check_eq("df_c2_b", 32'(outs_b), 32'(VFlRdy));
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    check_eq("df_c3_b", 32'(outs_b), 32'(VFlNrdy));
    idle();
    check_eq("df_wait_b", 32'(outs_b), 32'(VIwDone));
    idle();
    check_eq("df_run_b", 32'(outs_b), 32'(VDef));
`ifdef HAZ_PERF_CNT_EN
    check_eq("perf_flush_b", 32'(bus_b.flush_cycles), 32'd3);
    check_eq("perf_stall_b", 32'(bus_b.stall_cycles), 32'd0);
    check_eq("perf_flush_a", 32'(bus_a.flush_cycles), 32'd2);
    check_eq("perf_stall_a", 32'(bus_a.stall_cycles), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
